// File: rtl/apb_mon_pkg.sv
// apb_mon_pkg: shared types and constants for the APB protocol monitor.
// Phase enum, rule indices (bit index == error code), lowest-rule helper.
package apb_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_phase_e;

  localparam int NUM_RULES = 8;

  localparam int RULE_NO_ACCESS = 0;
  localparam int RULE_NO_SETUP  = 1;
  localparam int RULE_ADDR      = 2;
  localparam int RULE_WRITE     = 3;
  localparam int RULE_WDATA     = 4;
  localparam int RULE_DROP      = 5;
  localparam int RULE_TIMEOUT   = 6;
  localparam int RULE_STRB      = 7;

  // Lowest set index wins when several rules fire in one sample.
  function automatic logic [2:0] first_rule(
    input logic [NUM_RULES-1:0] v
  );
    logic [2:0] c;
    c = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (v[i]) c = 3'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/apb_mon_sat_counter.sv
// apb_mon_sat_counter: saturating event counter with synchronous clear.
// Ports: i_clk, i_reset (sync, active-high), i_clear, i_inc, o_count[W].
module apb_mon_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Clear first, then the same-cycle increment is applied.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= W'(i_inc);
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/apb_protocol_monitor.sv
// apb_protocol_monitor: passive APB completer-side protocol checker with
// sticky error flags and saturating transfer counters.
// Inputs : i_clk, i_reset, i_selx, i_enable, i_write, i_addr, i_wdata,
//          i_rdata, i_ready, i_slverr, i_strb (APB_MON_APB4_EN), i_clear.
// Outputs: o_phase, o_err_valid, o_err_code, o_err_sticky,
//          o_wr_count, o_rd_count, o_slverr_count.
// Define APB_MON_APB4_EN to add the strobe port and rule 7 checking.
module apb_protocol_monitor
  import apb_mon_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_selx,
  input  logic                    i_enable,
  input  logic                    i_write,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    i_ready,
  input  logic                    i_slverr,
`ifdef APB_MON_APB4_EN
  input  logic [DATA_WIDTH/8-1:0] i_strb,
`endif
  input  logic                    i_clear,
  output logic [1:0]              o_phase,
  output logic                    o_err_valid,
  output logic [2:0]              o_err_code,
  output logic [NUM_RULES-1:0]    o_err_sticky,
  output logic [CNT_WIDTH-1:0]    o_wr_count,
  output logic [CNT_WIDTH-1:0]    o_rd_count,
  output logic [CNT_WIDTH-1:0]    o_slverr_count
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_ACCESS = ACCESS;

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

  logic [1:0]            r_phase;
  logic                  r_armed;
  logic [WAIT_W-1:0]     r_wait;
  logic                  r_err_valid;
  logic [2:0]            r_err_code;
  logic [NUM_RULES-1:0]  r_sticky;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
`ifdef APB_MON_APB4_EN
  logic [DATA_WIDTH/8-1:0] r_strb;
`endif

  logic [1:0]            w_next;
  logic [WAIT_W-1:0]     w_wait_nxt;
  logic [NUM_RULES-1:0]  w_cmp;
  logic [NUM_RULES-1:0]  w_viol;
  logic                  w_cap;
  logic                  w_done;
  logic                  w_unused_rdata;

  // Read data is observed only; nothing checks it.
  assign w_unused_rdata = ^i_rdata;

  // Stability checks against the values captured at the SETUP sample.
  always_comb begin
    w_cmp = '0;
    w_cmp[RULE_ADDR]  = (i_addr != r_addr);
    w_cmp[RULE_WRITE] = (i_write != r_write);
    w_cmp[RULE_WDATA] = r_write && (i_wdata != r_wdata);
`ifdef APB_MON_APB4_EN
    w_cmp[RULE_STRB]  = (i_strb != r_strb) ||
                        (!r_write && (i_strb != '0));
`endif
  end

  always_comb begin
    w_next     = r_phase;
    w_wait_nxt = r_wait;
    w_viol     = '0;
    w_cap      = 1'b0;
    w_done     = 1'b0;
    if (r_armed) begin
      unique case (r_phase)
        ST_IDLE: begin
          if (i_selx && !i_enable) begin
            w_cap  = 1'b1;
            w_next = ST_SETUP;
          end else if (i_enable) begin
            w_viol[RULE_NO_SETUP] = 1'b1;
          end
        end
        ST_SETUP: begin
          if (i_selx && i_enable) begin
            w_viol = w_cmp;
            if (i_ready) begin
              w_done = 1'b1;
              w_next = ST_IDLE;
            end else begin
              w_next     = ST_ACCESS;
              w_wait_nxt = WAIT_W'(1);
              w_viol[RULE_TIMEOUT] = (WAIT_MAX == WAIT_W'(1));
            end
          end else begin
            w_viol[RULE_NO_ACCESS] = 1'b1;
            w_next = ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (!i_selx || !i_enable) begin
            w_viol[RULE_DROP] = 1'b1;
            w_next = ST_IDLE;
          end else begin
            w_viol = w_cmp;
            if (i_ready) begin
              w_done = 1'b1;
              w_next = ST_IDLE;
            end else if (r_wait != WAIT_MAX) begin
              // Counter parks at the limit so the timeout fires once.
              w_wait_nxt = r_wait + 1'b1;
              w_viol[RULE_TIMEOUT] = (r_wait == WAIT_MAX - 1'b1);
            end
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase     <= ST_IDLE;
      r_armed     <= 1'b0;
      r_wait      <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= '0;
      r_sticky    <= '0;
    end else begin
      // Reset may land mid-transfer; wait for an idle bus before checking.
      if (!r_armed && !i_selx) r_armed <= 1'b1;
      r_phase     <= w_next;
      r_wait      <= w_wait_nxt;
      r_err_valid <= |w_viol;
      if (|w_viol) r_err_code <= first_rule(w_viol);
      r_sticky    <= (i_clear ? '0 : r_sticky) | w_viol;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_cap) begin
      r_addr  <= i_addr;
      r_write <= i_write;
      r_wdata <= i_wdata;
`ifdef APB_MON_APB4_EN
      r_strb  <= i_strb;
`endif
    end
  end

  apb_mon_sat_counter #(.W(CNT_WIDTH)) u_wr_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_clear),
    .i_inc   (w_done && r_write),
    .o_count (o_wr_count)
  );

  apb_mon_sat_counter #(.W(CNT_WIDTH)) u_rd_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_clear),
    .i_inc   (w_done && !r_write),
    .o_count (o_rd_count)
  );

  apb_mon_sat_counter #(.W(CNT_WIDTH)) u_se_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_clear),
    .i_inc   (w_done && i_slverr),
    .o_count (o_slverr_count)
  );

  assign o_phase      = r_phase;
  assign o_err_valid  = r_err_valid;
  assign o_err_code   = r_err_code;
  assign o_err_sticky = r_sticky;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// tb_apb_protocol_monitor: directed APB sequences, a transfer-level
// reference model and literal spot checks for apb_protocol_monitor.
module tb_apb_protocol_monitor;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          selx = 1'b0, enable = 1'b0, write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0, rdata = '0;
  logic          ready = 1'b0, slverr = 1'b0, clear = 1'b0;
  logic [DW/8-1:0] strb = '0;

  logic [1:0]    o_phase;
  logic          o_err_valid;
  logic [2:0]    o_err_code;
  logic [7:0]    o_err_sticky;
  logic [CW-1:0] o_wr_count, o_rd_count, o_slverr_count;

  apb_protocol_monitor #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_selx(selx), .i_enable(enable), .i_write(write),
    .i_addr(addr), .i_wdata(wdata), .i_rdata(rdata),
    .i_ready(ready), .i_slverr(slverr),
`ifdef APB_MON_APB4_EN
    .i_strb(strb),
`endif
    .i_clear(clear),
    .o_phase(o_phase), .o_err_valid(o_err_valid),
    .o_err_code(o_err_code), .o_err_sticky(o_err_sticky),
    .o_wr_count(o_wr_count), .o_rd_count(o_rd_count),
    .o_slverr_count(o_slverr_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a transfer is "open" from its SETUP sample on;
  // m_n counts the bus samples seen since that SETUP sample.
  bit            m_started = 0;
  bit            m_armed;
  int            m_n;
  logic [AW-1:0] c_addr;
  bit            c_write;
  logic [DW-1:0] c_wdata;
  logic [DW/8-1:0] c_strb;
  int            m_wr, m_rd, m_se;
  bit            m_valid;
  logic [2:0]    m_code;
  logic [7:0]    m_sticky;
  logic [1:0]    m_phase;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  always @(posedge clk) begin
    logic [7:0] v;
    bit done;
    v = '0;
    done = 0;
    if (reset) begin
      m_started = 1;
      m_armed = 0; m_n = -1;
      m_wr = 0; m_rd = 0; m_se = 0;
      m_valid = 0; m_code = 0; m_sticky = 0; m_phase = 0;
    end else begin
      if (!m_armed) begin
        if (!selx) m_armed = 1;
      end else if (m_n < 0) begin
        if (selx && !enable) begin
          m_n = 0;
          c_addr = addr; c_write = write;
          c_wdata = wdata; c_strb = strb;
        end else if (enable) begin
          v[1] = 1;
        end
      end else if (!(selx && enable)) begin
        if (m_n == 0) v[0] = 1;
        else v[5] = 1;
        m_n = -1;
      end else begin
        v[2] = (addr != c_addr);
        v[3] = (write != c_write);
        v[4] = c_write && (wdata != c_wdata);
`ifdef APB_MON_APB4_EN
        v[7] = (strb != c_strb) || (!c_write && strb != 0);
`endif
        m_n++;
        if (ready) begin
          done = 1;
          m_n = -1;
        end else if (m_n == TO) begin
          v[6] = 1;
        end
      end
      if (clear) begin
        m_sticky = 0; m_wr = 0; m_rd = 0; m_se = 0;
      end
      m_sticky = m_sticky | v;
      m_valid = |v;
      for (int i = 7; i >= 0; i--) if (v[i]) m_code = 3'(i);
      if (done) begin
        if (c_write) m_wr = sat(m_wr + 1);
        else m_rd = sat(m_rd + 1);
        if (slverr) m_se = sat(m_se + 1);
      end
      m_phase = (m_n < 0) ? 2'd0 : ((m_n == 0) ? 2'd1 : 2'd2);
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      cmp("phase", 32'(o_phase), 32'(m_phase));
      cmp("err_valid", 32'(o_err_valid), 32'(m_valid));
      cmp("err_code", 32'(o_err_code), 32'(m_code));
      cmp("err_sticky", 32'(o_err_sticky), 32'(m_sticky));
      cmp("wr_count", 32'(o_wr_count), 32'(m_wr));
      cmp("rd_count", 32'(o_rd_count), 32'(m_rd));
      cmp("slverr_count", 32'(o_slverr_count), 32'(m_se));
    end
  end

  task automatic cyc(input bit s, input bit e, input bit w,
                     input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input bit r, input bit se = 0);
    selx = s; enable = e; write = w;
    addr = a; wdata = d; ready = r; slverr = se;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    idle();
    cmp("rst_phase", 32'(o_phase), 0);
    cmp("rst_sticky", 32'(o_err_sticky), 0);
    cmp("rst_wr", 32'(o_wr_count), 0);
    reset = 1'b0;
    idle();

    // 0-wait write then 2-wait read
    cyc(1, 0, 1, 10'h004, 32'hDEADBEEF, 0);
    cmp("t1_setup_phase", 32'(o_phase), 1);
    cyc(1, 1, 1, 10'h004, 32'hDEADBEEF, 1);
    cmp("t1_wr", 32'(o_wr_count), 1);
    cyc(1, 0, 0, 10'h008, 0, 0);
    cyc(1, 1, 0, 10'h008, 0, 0);
    cmp("t1_access_phase", 32'(o_phase), 2);
    cyc(1, 1, 0, 10'h008, 0, 0);
    cyc(1, 1, 0, 10'h008, 0, 1);
    cmp("t1_rd", 32'(o_rd_count), 1);
    cmp("t1_sticky", 32'(o_err_sticky), 0);
    idle();

    // address changes in ACCESS
    cyc(1, 0, 0, 10'h010, 0, 0);
    cyc(1, 1, 0, 10'h014, 0, 1);
    cmp("t2_valid", 32'(o_err_valid), 1);
    cmp("t2_code", 32'(o_err_code), 2);
    cmp("t2_sticky", 32'(o_err_sticky), 32'h04);
    idle();
    cmp("t2_pulse_end", 32'(o_err_valid), 0);

    // 16 wait states then ready
    cyc(1, 0, 1, 10'h020, 32'h1234, 0);
    for (int i = 1; i < TO; i++) cyc(1, 1, 1, 10'h020, 32'h1234, 0);
    cmp("t3_before_to", 32'(o_err_valid), 0);
    cyc(1, 1, 1, 10'h020, 32'h1234, 0);
    cmp("t3_to_valid", 32'(o_err_valid), 1);
    cmp("t3_to_code", 32'(o_err_code), 6);
    cyc(1, 1, 1, 10'h020, 32'h1234, 1);
    cmp("t3_once", 32'(o_err_valid), 0);
    cmp("t3_wr", 32'(o_wr_count), 2);
    idle();
    cmp("t3_sticky", 32'(o_err_sticky), 32'h44);

    // enable without SETUP, then clear
    cyc(0, 1, 0, '0, '0, 0);
    cmp("t4_code", 32'(o_err_code), 1);
    clear = 1'b1;
    idle();
    clear = 1'b0;
    cmp("t4_clr_sticky", 32'(o_err_sticky), 0);
    cmp("t4_clr_wr", 32'(o_wr_count), 0);
    cmp("t4_clr_rd", 32'(o_rd_count), 0);
    clear = 1'b1;
    cyc(0, 1, 0, '0, '0, 0);
    clear = 1'b0;
    cmp("t4_clr_plus_err", 32'(o_err_sticky), 32'h02);
    idle();

    // SETUP then idle (rule 0); enable dropped in ACCESS (rule 5)
    cyc(1, 0, 0, 10'h030, 0, 0);
    idle();
    cmp("r0_code", 32'(o_err_code), 0);
    cmp("r0_valid", 32'(o_err_valid), 1);
    cyc(1, 0, 0, 10'h034, 0, 0);
    cyc(1, 1, 0, 10'h034, 0, 0);
    cyc(1, 0, 0, 10'h034, 0, 0);
    cmp("r5_code", 32'(o_err_code), 5);
    idle();

    // addr and wdata both change: lowest index reported
    cyc(1, 0, 1, 10'h040, 32'hAAAA, 0);
    cyc(1, 1, 1, 10'h044, 32'h5555, 1);
    cmp("multi_code", 32'(o_err_code), 2);
    cmp("multi_sticky", 32'(o_err_sticky), 32'h37);

    // back-to-back write then read
    cyc(1, 0, 1, 10'h050, 32'h1, 0);
    cyc(1, 1, 1, 10'h050, 32'h1, 1);
    cyc(1, 0, 0, 10'h054, 0, 0);
    cyc(1, 1, 0, 10'h054, 0, 1);
    cmp("b2b_valid", 32'(o_err_valid), 0);
    cmp("b2b_wr", 32'(o_wr_count), 2);
    cmp("b2b_rd", 32'(o_rd_count), 1);

    // slave error on a write
    cyc(1, 0, 1, 10'h060, 32'h7, 0);
    cyc(1, 1, 1, 10'h060, 32'h7, 1, 1);
    cmp("se_count", 32'(o_slverr_count), 1);
    idle();

    // reset mid-ACCESS with the bus still in a transfer
    cyc(1, 0, 0, 10'h070, 0, 0);
    cyc(1, 1, 0, 10'h070, 0, 0);
    reset = 1'b1;
    cyc(1, 1, 0, 10'h070, 0, 0);
    reset = 1'b0;
    cyc(1, 1, 0, 10'h070, 0, 0);
    cyc(1, 1, 0, 10'h070, 0, 0);
    cmp("rm_valid", 32'(o_err_valid), 0);
    cmp("rm_sticky", 32'(o_err_sticky), 0);
    cmp("rm_phase", 32'(o_phase), 0);
    idle();
    cyc(1, 0, 1, 10'h080, 32'h9, 0);
    cyc(1, 1, 0, 10'h080, 32'h9, 1);
    cmp("rm_armed_code", 32'(o_err_code), 3);
    cmp("rm_armed_sticky", 32'(o_err_sticky), 32'h08);
    idle();

    // counter saturation
    clear = 1'b1;
    idle();
    clear = 1'b0;
    for (int i = 0; i < CMAX + 2; i++) begin
      cyc(1, 0, 1, 10'h100, 32'(i), 0);
      cyc(1, 1, 1, 10'h100, 32'(i), 1);
    end
    cmp("sat_wr", 32'(o_wr_count), 32'hF);

`ifdef APB_MON_APB4_EN
    idle();
    strb = '1;
    strb[DW/8-1:2] = '0;
    cyc(1, 0, 0, 10'h200, 0, 0);
    cyc(1, 1, 0, 10'h200, 0, 1);
    strb = '0;
    cmp("strb_code", 32'(o_err_code), 7);
    cmp("strb_sticky7", 32'(o_err_sticky[7]), 1);
`endif

    idle();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_protocol_monitor.md
# apb_protocol_monitor

Synthesizable, parametrised APB protocol monitor that sits passively on one APB completer interface in the verification environment. It tracks the IDLE/SETUP/ACCESS phase with its own state machine, checks handshake and signal-stability rules, detects wait-state timeouts, and counts completed transfers. It replaces per-cycle concurrent checks with registered, sticky, software-readable error reporting.

## Interface
- `ADDR_WIDTH`, 10, address width
- `DATA_WIDTH`, 32, data width (multiple of 8)
- `TIMEOUT_CYCLES`, 16, maximum wait states allowed in ACCESS (≥1)
- `CNT_WIDTH`, 16, width of the transfer counters
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `selx`, `enable`, `write`  in  1  APB select, enable, direction
- `addr`  in  ADDR_WIDTH  APB address
- `wdata`  in  DATA_WIDTH  write data
- `rdata`  in  DATA_WIDTH  read data (observed only)
- `ready`, `slverr`  in  1  completer ready, error response
- `strb`  in  DATA_WIDTH/8  write strobes (only with `APB_MON_APB4_EN`)
- `clear`  in  1  zeroes sticky errors and counters
- `phase`  out  2  current monitor state (0 IDLE, 1 SETUP, 2 ACCESS)
- `err_valid`  out  1  one-cycle pulse, violation detected
- `err_code`  out  3  lowest-index rule violated in that sample
- `err_sticky`  out  8  per-rule sticky flags
- `wr_count`, `rd_count`, `slverr_count`  out  CNT_WIDTH  completed writes, completed reads, completions with slverr

## Operation
- Rules (bit index = code): 0 SETUP not followed by ACCESS; 1 enable without preceding SETUP; 2 addr changed SETUP→ACCESS/wait; 3 write changed; 4 wdata changed (writes only); 5 selx or enable dropped before ready; 6 timeout; 7 strobe error.
- SETUP sample (`selx && !enable` in IDLE): capture addr, write, wdata (and strb); next SETUP.
- IDLE: `enable` high → rule 1, stay IDLE.
- SETUP: next sample must be `selx && enable`, else rule 0, → IDLE. If OK: compare against captured values (rules 2–4, 7). `ready` → complete, → IDLE; else → ACCESS, wait counter = 1.
- ACCESS: `!selx || !enable` → rule 5, → IDLE. Otherwise compare again; `ready` → complete, → IDLE; else increment wait counter. Rule 6 fires once when the counter reaches TIMEOUT_CYCLES; monitoring continues in ACCESS.
- Complete: increment wr_count or rd_count per write; also increment slverr_count if slverr. All counters saturate at all-ones.
- Back-to-back: a SETUP sample in the IDLE state directly after completion is legal.
- Arming: after reset, checks are disabled until the first sample with `selx == 0`. This prevents false errors from reset asserted mid-transfer.
- Multiple rules in one sample: all sticky bits set; err_code = lowest index.
- `clear` together with a new violation: sticky bits and counters clear, then the new event is applied in the same cycle (the new event survives).

## Timing
- Reset values: phase 0, err_valid 0, err_code 0, err_sticky 0, all counters 0, disarmed.
- Latency: err_valid, err_code, err_sticky, counters and phase update on the clock edge after the sampled bus cycle (1-cycle latency).
- err_valid is high for exactly one cycle per violating sample.

## Configuration
- `APB_MON_APB4_EN` defined:
  - `strb` port present.
  - Rule 7 checks that strb is stable SETUP→completion and that strb == 0 on reads.
- Not defined:
  - No `strb` port.
  - err_sticky[7] tied to 0.
  - err_code never equals 7.

## Structure
- Package `apb_mon_pkg` contains:
  - `apb_phase_e` enum (IDLE/SETUP/ACCESS)
  - rule-index localparams
  - `NUM_RULES = 8`
- Sub-module `apb_mon_sat_counter` (parametrised width; inc/clear; saturating), instantiated three times.

## Test plan
- Write to 0x004 with data 0xDEADBEEF and 0 wait states, then read to 0x008 with 2 wait states → wr_count 1, rd_count 1, err_sticky 0x00.
- addr changes 0x010→0x014 in the ACCESS cycle → err_valid pulse, err_code 2, err_sticky 0x04.
- ready held low for 16 ACCESS cycles (TIMEOUT_CYCLES=16), then high → single rule-6 pulse at wait 16; transfer still counted.
- enable asserted from IDLE without SETUP → err_code 1; then `clear` → err_sticky 0, counters 0.
- Reset asserted mid-ACCESS while the bus keeps enable high; selx low 3 cycles later → no errors until armed; next transfer is checked normally.
- With `APB_MON_APB4_EN`: read with strb=0x3 → err_code 7, err_sticky bit 7 set; slverr=1 on a write completion → slverr_count 1.
